// File: rtl/apb_global_pkg.sv
// Shared APB widths, address map defaults and the transfer/protection/controller-state types.
// Every APB block and the VIP agents import this package.
package apb_global_pkg;

  localparam int NO_OF_SLAVES      = 1;
  localparam int ADDRESS_WIDTH     = 32;
  localparam int DATA_WIDTH        = 32;
  localparam int SLAVE_MEMORY_SIZE = 12;
  localparam int SLAVE_MEMORY_GAP  = 2;
  localparam int MAX_WAIT_STATES   = 16;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } tx_type_e;

  typedef enum logic [2:0] {
    NORMAL_SECURE_DATA               = 3'b000,
    PRIVILEGED_SECURE_DATA           = 3'b001,
    NORMAL_NONSECURE_DATA            = 3'b010,
    PRIVILEGED_NONSECURE_DATA        = 3'b011,
    NORMAL_SECURE_INSTRUCTION        = 3'b100,
    PRIVILEGED_SECURE_INSTRUCTION    = 3'b101,
    NORMAL_NONSECURE_INSTRUCTION     = 3'b110,
    PRIVILEGED_NONSECURE_INSTRUCTION = 3'b111
  } protection_type_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_ctrl_state_e;

endpackage

// File: rtl/apb_master_ctrl_if.sv
// APB3/APB4 bus bundle between one master and its slaves; pselx is one-hot per slave.
// No storage here: timing and backpressure (pready) belong to the endpoints.
interface apb_master_ctrl_if #(
  parameter int NO_OF_SLAVES  = apb_global_pkg::NO_OF_SLAVES,
  parameter int ADDRESS_WIDTH = apb_global_pkg::ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = apb_global_pkg::DATA_WIDTH
) ();

  logic [NO_OF_SLAVES-1:0]   pselx;
  logic                      penable;
  logic                      pwrite;
  logic [ADDRESS_WIDTH-1:0]  paddr;
  logic [DATA_WIDTH-1:0]     pwdata;
  logic [DATA_WIDTH/8-1:0]   pstrb;
  logic [2:0]                pprot;
  logic                      pready;
  logic                      pslverr;
  logic [DATA_WIDTH-1:0]     prdata;

  modport master (
    output pselx, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  pready, pslverr, prdata
  );

  modport slave (
    input  pselx, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output pready, pslverr, prdata
  );

endinterface

// File: rtl/apb_addr_decoder.sv
// Combinational address-window decoder: one-hot select plus hit flag, zero latency.
// Window i covers [i*(SIZE KB + GAP), i*(SIZE KB + GAP) + SIZE KB - 1]; compares never wrap.
module apb_addr_decoder #(
  parameter int NO_OF_SLAVES      = apb_global_pkg::NO_OF_SLAVES,
  parameter int ADDRESS_WIDTH     = apb_global_pkg::ADDRESS_WIDTH,
  parameter int DATA_WIDTH        = apb_global_pkg::DATA_WIDTH,
  parameter int SLAVE_MEMORY_SIZE = apb_global_pkg::SLAVE_MEMORY_SIZE,
  parameter int SLAVE_MEMORY_GAP  = apb_global_pkg::SLAVE_MEMORY_GAP,
  parameter int MAX_WAIT_STATES   = apb_global_pkg::MAX_WAIT_STATES
) (
  input  logic [ADDRESS_WIDTH-1:0] addr_i,
  output logic [NO_OF_SLAVES-1:0]  sel_o,
  output logic                     hit_o
);

  localparam int unsigned WIN_BYTES  = SLAVE_MEMORY_SIZE * 1024;
  localparam int unsigned WIN_STRIDE = WIN_BYTES + SLAVE_MEMORY_GAP;
  // Headroom so window bases/limits past the address space simply never match.
  localparam int          EXT_W      = ADDRESS_WIDTH + 33;
  // An illegal configuration decodes nothing, so every request returns a decode error.
  localparam bit          CFG_OK     = (DATA_WIDTH % 8 == 0) && (MAX_WAIT_STATES >= 1);

  logic [EXT_W-1:0] addr_ext;

  assign addr_ext = {33'd0, addr_i};

  for (genvar g = 0; g < NO_OF_SLAVES; g++) begin : g_win
    localparam logic [EXT_W-1:0] BASE  = EXT_W'(g) * EXT_W'(WIN_STRIDE);
    localparam logic [EXT_W-1:0] LIMIT = BASE + EXT_W'(WIN_BYTES) - EXT_W'(1);
    assign sel_o[g] = (addr_ext >= BASE) && (addr_ext <= LIMIT);
  end

  assign hit_o = CFG_OK && (|sel_o);

endmodule

// File: rtl/apb_master_ctrl.sv
// APB master sequencer: accept -> SETUP -> ACCESS, response 3 cycles after accept (+1 per wait state, 1 for decode error).
// One request in flight; req_ready drops while a transfer is on the bus, responses are never backpressured.
module apb_master_ctrl #(
  parameter int NO_OF_SLAVES      = apb_global_pkg::NO_OF_SLAVES,
  parameter int ADDRESS_WIDTH     = apb_global_pkg::ADDRESS_WIDTH,
  parameter int DATA_WIDTH        = apb_global_pkg::DATA_WIDTH,
  parameter int SLAVE_MEMORY_SIZE = apb_global_pkg::SLAVE_MEMORY_SIZE,
  parameter int SLAVE_MEMORY_GAP  = apb_global_pkg::SLAVE_MEMORY_GAP,
  parameter int MAX_WAIT_STATES   = apb_global_pkg::MAX_WAIT_STATES
) (
  input  logic                      pclk,
  input  logic                      preset_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDRESS_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  input  logic [DATA_WIDTH/8-1:0]   req_strb,
  input  logic [2:0]                req_prot,
  output logic                      rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_slverr,
  output logic                      rsp_decerr,
  output logic                      rsp_timeout,
  apb_master_ctrl_if.master         apb
);

  import apb_global_pkg::*;

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int WCNT_W = $clog2(MAX_WAIT_STATES + 1);

  apb_ctrl_state_e           state_q;
  logic                      en_q;
  logic [WCNT_W-1:0]         wait_q;
  logic [WCNT_W-1:0]         wait_d;
  logic [NO_OF_SLAVES-1:0]   dec_sel;
  logic                      dec_hit;
  logic [NO_OF_SLAVES-1:0]   pselx_q;
  logic                      penable_q;
  tx_type_e                  dir_q;
  logic [ADDRESS_WIDTH-1:0]  paddr_q;
  logic [DATA_WIDTH-1:0]     pwdata_q;
  logic [STRB_W-1:0]         pstrb_q;
  protection_type_e          pprot_q;
  logic                      rsp_valid_q;
  logic [DATA_WIDTH-1:0]     rsp_rdata_q;
  logic                      rsp_slverr_q;
  logic                      rsp_decerr_q;
  logic                      rsp_timeout_q;

  apb_addr_decoder #(
    .NO_OF_SLAVES      (NO_OF_SLAVES),
    .ADDRESS_WIDTH     (ADDRESS_WIDTH),
    .DATA_WIDTH        (DATA_WIDTH),
    .SLAVE_MEMORY_SIZE (SLAVE_MEMORY_SIZE),
    .SLAVE_MEMORY_GAP  (SLAVE_MEMORY_GAP),
    .MAX_WAIT_STATES   (MAX_WAIT_STATES)
  ) u_addr_decoder (
    .addr_i (req_addr),
    .sel_o  (dec_sel),
    .hit_o  (dec_hit)
  );

  // en_q keeps req_ready low for the first cycle after reset release.
  assign req_ready = en_q && (state_q == IDLE);
  assign wait_d    = wait_q + WCNT_W'(1);

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q       <= IDLE;
      en_q          <= 1'b0;
      wait_q        <= '0;
      pselx_q       <= '0;
      penable_q     <= 1'b0;
      dir_q         <= READ;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pprot_q       <= NORMAL_SECURE_DATA;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_decerr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      en_q          <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_decerr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready) begin
            if (dec_hit) begin
              state_q  <= SETUP;
              wait_q   <= '0;
              pselx_q  <= dec_sel;
              dir_q    <= tx_type_e'(req_write);
              paddr_q  <= req_addr;
              pwdata_q <= req_wdata;
              pstrb_q  <= req_write ? req_strb : '0;
              pprot_q  <= protection_type_e'(req_prot);
            end else begin
              rsp_valid_q  <= 1'b1;
              rsp_decerr_q <= 1'b1;
            end
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: begin
          // pslverr only means something once the slave signals pready.
          if (apb.pready) begin
            state_q      <= IDLE;
            pselx_q      <= '0;
            penable_q    <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_slverr_q <= apb.pslverr;
            rsp_rdata_q  <= (dir_q == READ && !apb.pslverr) ? apb.prdata : '0;
          end else if (wait_q == WCNT_W'(MAX_WAIT_STATES)) begin
            state_q       <= IDLE;
            pselx_q       <= '0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_timeout_q <= 1'b1;
          end else begin
            wait_q <= wait_d;
          end
        end
        default: begin
          state_q   <= IDLE;
          pselx_q   <= '0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  assign apb.pselx   = pselx_q;
  assign apb.penable = penable_q;
  assign apb.pwrite  = (dir_q == WRITE);
  assign apb.paddr   = paddr_q;
  assign apb.pwdata  = pwdata_q;
  assign apb.pstrb   = pstrb_q;
  assign apb.pprot   = pprot_q;

  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_slverr  = rsp_slverr_q;
  assign rsp_decerr  = rsp_decerr_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Randomised scoreboard bench for apb_master_ctrl with two slave windows and a 4-wait-state limit.
// A scripted slave model drives pready/pslverr/prdata per transfer; a monitor checks every response.
module tb_apb_master_ctrl;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int NS  = 2;
  localparam int MSZ = 12;
  localparam int GAP = 2;
  localparam int MW  = 4;

  typedef struct packed {
    logic        decerr;
    logic        slverr;
    logic        timeout;
    logic [31:0] rdata;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct packed {
    int          w;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic [3:0]  strb;
    logic [2:0]  prot;
    logic [1:0]  sel;
  } slv_t;

  logic          pclk;
  logic          preset_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [SW-1:0] req_strb;
  logic [2:0]    req_prot;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_slverr;
  logic          rsp_decerr;
  logic          rsp_timeout;

  exp_t exp_q[$];
  slv_t slv_q[$];
  int   n_checks = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_rsp_cyc = -1;

  apb_master_ctrl_if #(.NO_OF_SLAVES(NS), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

  apb_master_ctrl #(
    .NO_OF_SLAVES      (NS),
    .ADDRESS_WIDTH     (AW),
    .DATA_WIDTH        (DW),
    .SLAVE_MEMORY_SIZE (MSZ),
    .SLAVE_MEMORY_GAP  (GAP),
    .MAX_WAIT_STATES   (MW)
  ) dut (
    .pclk        (pclk),
    .preset_n    (preset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_strb    (req_strb),
    .req_prot    (req_prot),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_slverr  (rsp_slverr),
    .rsp_decerr  (rsp_decerr),
    .rsp_timeout (rsp_timeout),
    .apb         (apb)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  always @(posedge pclk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference address map: window index by division, hit if the offset lands before the gap.
  function automatic void model_decode(input logic [31:0] a, output bit hit, output int idx);
    longint unsigned stride;
    longint unsigned la;
    stride = longint'(MSZ) * 1024 + longint'(GAP);
    la     = {32'd0, a};
    idx    = int'(la / stride);
    hit    = (la / stride < longint'(NS)) && (la % stride < longint'(MSZ) * 1024);
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input logic [2:0] pr, input int w,
                      input logic err, input logic [31:0] rd, output int acc);
    bit   hit;
    int   idx;
    int   guard;
    exp_t e;
    slv_t s;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    req_strb  = st;
    req_prot  = pr;
    guard = 0;
    while (!req_ready && guard < 100) begin
      @(negedge pclk);
      guard++;
    end
    if (!req_ready) begin
      chk("req_ready_bound", 64'(req_ready), 64'd1);
      req_valid = 1'b0;
      acc = -1;
      return;
    end
    model_decode(a, hit, idx);
    acc       = cyc;
    e.acc     = cyc;
    e.decerr  = !hit;
    e.timeout = hit && (w > MW);
    e.slverr  = hit && !e.timeout && err;
    e.rdata   = (hit && !e.timeout && !err && !wr) ? rd : 32'd0;
    e.lat     = !hit ? 1 : (e.timeout ? 3 + MW : 3 + w);
    exp_q.push_back(e);
    if (hit) begin
      s        = '0;
      s.w      = w;
      s.err    = err;
      s.rdata  = rd;
      s.addr   = a;
      s.wdata  = wd;
      s.write  = wr;
      s.strb   = wr ? st : 4'd0;
      s.prot   = pr;
      s.sel    = (idx == 0) ? 2'b01 : 2'b10;
      slv_q.push_back(s);
    end
    @(negedge pclk);
    req_valid = 1'b0;
  endtask

  // Response monitor.
  always @(negedge pclk) begin
    exp_t e;
    if (preset_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_rsp: rsp_valid=1 at cycle %0d, required no response", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_latency", 64'(cyc - e.acc), 64'(e.lat));
        chk("rsp_decerr",  64'(rsp_decerr),  64'(e.decerr));
        chk("rsp_slverr",  64'(rsp_slverr),  64'(e.slverr));
        chk("rsp_timeout", 64'(rsp_timeout), 64'(e.timeout));
        chk("rsp_rdata",   64'(rsp_rdata),   64'(e.rdata));
      end
      last_rsp_cyc = cyc;
    end
  end

  // Slave model: follows the script queued for each bus transfer.
  initial begin
    slv_t cur;
    int   cnt;
    cur = '0;
    cnt = 0;
    apb.pready  = 1'b0;
    apb.pslverr = 1'b0;
    apb.prdata  = '0;
    forever begin
      @(negedge pclk);
      if (preset_n && (|apb.pselx) && !apb.penable) begin
        if (slv_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_setup: pselx=%b addr=0x%0h, required no transfer", apb.pselx, apb.paddr);
          cur = '0;
        end else begin
          cur = slv_q.pop_front();
          chk("setup_pselx",  64'(apb.pselx),  64'(cur.sel));
          chk("setup_paddr",  64'(apb.paddr),  64'(cur.addr));
          chk("setup_pwrite", 64'(apb.pwrite), 64'(cur.write));
          chk("setup_pwdata", 64'(apb.pwdata), 64'(cur.wdata));
          chk("setup_pstrb",  64'(apb.pstrb),  64'(cur.strb));
          chk("setup_pprot",  64'(apb.pprot),  64'(cur.prot));
        end
        cnt = 0;
        apb.pready  = 1'b0;
        apb.pslverr = 1'($urandom);
        apb.prdata  = $urandom;
      end else if (preset_n && (|apb.pselx) && apb.penable) begin
        chk("access_paddr_stable", 64'(apb.paddr), 64'(cur.addr));
        chk("access_pselx_stable", 64'(apb.pselx), 64'(cur.sel));
        if (cnt == cur.w) begin
          apb.pready  = 1'b1;
          apb.pslverr = cur.err;
          apb.prdata  = cur.rdata;
        end else begin
          apb.pready  = 1'b0;
          apb.pslverr = 1'($urandom);
          apb.prdata  = $urandom;
        end
        cnt++;
      end else begin
        apb.pready  = 1'b0;
        apb.pslverr = 1'b0;
        apb.prdata  = $urandom;
      end
    end
  end

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(negedge pclk);
      guard++;
    end
    chk("drain_outstanding", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int acc;
    int acc2;
    int sel;
    logic [31:0] a;
    preset_n  = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_strb  = '0;
    req_prot  = '0;
    #3;
    chk("rst_pselx",     64'(apb.pselx),   64'd0);
    chk("rst_penable",   64'(apb.penable), 64'd0);
    chk("rst_paddr",     64'(apb.paddr),   64'd0);
    chk("rst_pstrb",     64'(apb.pstrb),   64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid),   64'd0);
    chk("rst_req_ready", 64'(req_ready),   64'd0);
    @(negedge pclk);
    @(negedge pclk);
    preset_n = 1'b1;
    chk("ready_low_first_cycle", 64'(req_ready), 64'd0);
    @(negedge pclk);
    chk("ready_high_after_enable", 64'(req_ready), 64'd1);

    // Directed cases.
    send(1'b1, 32'h10,   32'hA5A5A5A5, 4'hF, 3'b000, 0, 1'b0, 32'h11111111, acc);
    send(1'b0, 32'h2FFC, 32'h0,        4'hF, 3'b010, 2, 1'b0, 32'hDEADBEEF, acc);
    send(1'b0, 32'h100,  32'h0,        4'h3, 3'b001, 1, 1'b1, 32'h12345678, acc);
    send(1'b0, 32'h3000, 32'h0,        4'h0, 3'b000, 0, 1'b0, 32'h0,        acc);
    send(1'b0, 32'h3001, 32'h0,        4'h0, 3'b000, 0, 1'b0, 32'h0,        acc);
    send(1'b1, 32'h3002, 32'hCAFEF00D, 4'h5, 3'b111, 0, 1'b0, 32'h0,        acc);
    send(1'b0, 32'h2FFF, 32'h0,        4'hF, 3'b000, 0, 1'b0, 32'h0BADF00D, acc);
    send(1'b0, 32'h6001, 32'h0,        4'hF, 3'b100, 1, 1'b0, 32'h600D600D, acc);
    send(1'b0, 32'h6002, 32'h0,        4'hF, 3'b000, 0, 1'b0, 32'h0,        acc);
    send(1'b0, 32'h44,   32'h0,        4'hF, 3'b000, MW, 1'b0, 32'h5A5A5A5A, acc);
    send(1'b1, 32'h20,   32'h77777777, 4'hF, 3'b000, MW + 1, 1'b0, 32'h0,   acc);
    send(1'b0, 32'h40,   32'h0,        4'hF, 3'b000, 0, 1'b0, 32'h87654321, acc2);
    chk("accept_with_timeout_rsp", 64'(acc2), 64'(last_rsp_cyc));

    // Randomised traffic.
    for (int i = 0; i < 250; i++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) @(negedge pclk);
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       a = $urandom_range(32'h2FFF, 0);
        1:       a = $urandom_range(32'h3005, 32'h2FFC);
        2:       a = $urandom_range(32'h6005, 32'h5FFE);
        default: a = $urandom;
      endcase
      send(1'($urandom), a, $urandom, 4'($urandom), 3'($urandom),
           int'($urandom_range(0, MW + 1)), ($urandom_range(0, 3) == 0), $urandom, acc);
    end
    drain();

    // Reset in the middle of ACCESS.
    send(1'b0, 32'h80, 32'h0, 4'hF, 3'b000, MW + 1, 1'b0, 32'h0, acc);
    @(negedge pclk);
    chk("mid_access_penable", 64'(apb.penable), 64'd1);
    #2;
    preset_n = 1'b0;
    #1;
    chk("async_rst_pselx",   64'(apb.pselx),   64'd0);
    chk("async_rst_penable", 64'(apb.penable), 64'd0);
    exp_q.delete();
    slv_q.delete();
    @(negedge pclk);
    @(negedge pclk);
    preset_n = 1'b1;
    chk("ready_low_after_release", 64'(req_ready), 64'd0);
    @(negedge pclk);
    chk("ready_high_second_edge", 64'(req_ready), 64'd1);
    send(1'b0, 32'h3010, 32'h0, 4'hF, 3'b000, 1, 1'b0, 32'h13572468, acc);
    send(1'b1, 32'h8,    32'h2468ACE0, 4'hC, 3'b011, 0, 1'b0, 32'h0, acc);
    drain();
    chk("no_pending_slave_scripts", 64'(slv_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
